// File: rtl/mb_rtu_tx_gen_pkg.sv
// Shared constants and types for the Modbus RTU slave response-frame builder.
package mb_rtu_pkg;

    localparam logic [7:0]  FUN_RD_HOLD     = 8'h03;
    localparam logic [7:0]  FUN_RD_IN       = 8'h04;
    localparam logic [7:0]  FUN_WR_SINGLE   = 8'h06;
    localparam logic [7:0]  FUN_WR_MULTI    = 8'h10;

    localparam logic [7:0]  EXC_ILLEGAL_FUN = 8'h01;
    localparam logic [7:0]  EXC_ILLEGAL_VAL = 8'h03;

    localparam logic [15:0] CRC_INIT        = 16'hFFFF;
    localparam logic [15:0] CRC_POLY        = 16'hA001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_FETCH,
        ST_BODY,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        FMT_READ,
        FMT_WRITE,
        FMT_EXC
    } fmt_t;

    function automatic logic fun_is_read(input logic [7:0] fun);
        return (fun == FUN_RD_HOLD) || (fun == FUN_RD_IN);
    endfunction

    function automatic logic fun_supported(input logic [7:0] fun);
        return fun_is_read(fun) || (fun == FUN_WR_SINGLE) || (fun == FUN_WR_MULTI);
    endfunction

endpackage

// File: rtl/mb_rtu_tx_gen_crc16.sv
// Combinational Modbus CRC-16 byte step (reflected 0xA001); the CRC register lives in the caller.
module crc16_modbus_d8
    import mb_rtu_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, data};
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ CRC_POLY;
            else      c = c >> 1;
        end
        crc_out = c;
    end

endmodule

// File: rtl/mb_rtu_tx_gen.sv
// Modbus RTU slave response-frame builder: read / write-echo / exception frames with inline CRC,
// streamed one byte at a time over a valid/ready handshake.
module mb_rtu_tx_gen
    import mb_rtu_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR = 8'h01,
    parameter int unsigned MAX_REGS   = 125,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [7:0]  mb_fun,
    input  logic [15:0] mb_addr,
    input  logic [15:0] mb_num,
    input  logic        exc_en,
    input  logic [7:0]  exc_code,
    output logic        payload_req,
    input  logic [7:0]  payload_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic        busy,
    output logic        tx_done,
    output logic        err_fun
);

    state_t             state_q, state_d;
    fmt_t               fmt_q;
    logic [7:0]         fun_q, exc_code_q, exc_q, bc_q, pl_q;
    logic [15:0]        addr_q, num_q, crc_q, crc_nxt;
    logic               exc_en_q, pend_q, err_q;
    logic [2:0]         hdr_idx_q, hdr_len;
    logic [CNT_W-1:0]   cnt_q;
    logic               start_ok, start_bad, accept, hdr_last, body_last;

    assign start_ok  = (state_q == ST_IDLE) && tx_start && (exc_en || fun_supported(mb_fun));
    assign start_bad = (state_q == ST_IDLE) && tx_start && !exc_en && !fun_supported(mb_fun);
    assign accept    = tx_valid && tx_ready;
    assign hdr_len   = (fmt_q == FMT_WRITE) ? 3'd6 : 3'd3;
    assign hdr_last  = (hdr_idx_q == hdr_len - 3'd1);
    assign body_last = (cnt_q == CNT_W'(bc_q) - CNT_W'(1));

    crc16_modbus_d8 u_crc (
        .crc_in  (crc_q),
        .data    (tx_data),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_HDR;
            ST_HDR:    if (accept && hdr_last)
                           state_d = (fmt_q == FMT_READ) ? ST_FETCH : ST_CRC_LO;
            ST_FETCH:  state_d = ST_BODY;
            ST_BODY:   if (accept) state_d = body_last ? ST_CRC_LO : ST_FETCH;
            ST_CRC_LO: if (accept) state_d = ST_CRC_HI;
            ST_CRC_HI: if (accept) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_q      <= FMT_WRITE;
            fun_q      <= '0;
            addr_q     <= '0;
            num_q      <= '0;
            exc_en_q   <= 1'b0;
            exc_code_q <= '0;
            exc_q      <= '0;
            bc_q       <= '0;
            pl_q       <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            hdr_idx_q  <= '0;
            cnt_q      <= '0;
            crc_q      <= CRC_INIT;
        end else begin
            err_q  <= start_bad;
            pend_q <= payload_req;
            // payload_data is only valid the cycle after the request
            if (pend_q) pl_q <= payload_data;
            if (start_ok) begin
                fun_q      <= mb_fun;
                addr_q     <= mb_addr;
                num_q      <= mb_num;
                exc_en_q   <= exc_en;
                exc_code_q <= exc_code;
            end
            if (state_q == ST_LOAD) begin
                crc_q     <= CRC_INIT;
                hdr_idx_q <= '0;
                cnt_q     <= '0;
                bc_q      <= {num_q[6:0], 1'b0};
                if (exc_en_q) begin
                    fmt_q <= FMT_EXC;
                    exc_q <= exc_code_q;
                end else if (fun_is_read(fun_q) &&
                             ((num_q == 16'd0) || (num_q > 16'(MAX_REGS)))) begin
                    fmt_q <= FMT_EXC;
                    exc_q <= EXC_ILLEGAL_VAL;
                end else begin
                    fmt_q <= fun_is_read(fun_q) ? FMT_READ : FMT_WRITE;
                end
            end
            if (accept && (state_q == ST_HDR || state_q == ST_BODY)) crc_q <= crc_nxt;
            if (accept && state_q == ST_HDR)  hdr_idx_q <= hdr_idx_q + 3'd1;
            if (accept && state_q == ST_BODY) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        tx_valid    = 1'b0;
        tx_data     = '0;
        tx_last     = 1'b0;
        tx_done     = 1'b0;
        payload_req = 1'b0;
        busy        = (state_q != ST_IDLE);
        err_fun     = err_q;
        unique case (state_q)
            ST_HDR: begin
                tx_valid = 1'b1;
                unique case (hdr_idx_q)
                    3'd0:    tx_data = SLAVE_ADDR;
                    3'd1:    tx_data = (fmt_q == FMT_EXC) ? (fun_q | 8'h80) : fun_q;
                    3'd2:    tx_data = (fmt_q == FMT_EXC)  ? exc_q :
                                       (fmt_q == FMT_READ) ? bc_q  : addr_q[15:8];
                    3'd3:    tx_data = addr_q[7:0];
                    3'd4:    tx_data = num_q[15:8];
                    default: tx_data = num_q[7:0];
                endcase
            end
            ST_FETCH:  payload_req = 1'b1;
            ST_BODY: begin
                tx_valid = !pend_q;
                tx_data  = pl_q;
            end
            ST_CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = crc_q[7:0];
            end
            ST_CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = crc_q[15:8];
                tx_last  = 1'b1;
            end
            ST_DONE:   tx_done = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_mb_rtu_tx_gen.sv
// Scoreboard bench for mb_rtu_tx_gen: frames are predicted from the Modbus rules and checked by a monitor.
module tb_mb_rtu_tx_gen;
    import mb_rtu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, tx_start = 1'b0;
    logic [7:0]  mb_fun = '0, exc_code = '0, payload_data = '0, tx_data;
    logic [15:0] mb_addr = '0, mb_num = '0;
    logic        exc_en = 1'b0, tx_ready = 1'b0;
    logic        payload_req, tx_valid, tx_last, busy, tx_done, err_fun;

    always #5 clk = ~clk;

    mb_rtu_tx_gen #(.SLAVE_ADDR(8'h01), .MAX_REGS(125), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .mb_fun(mb_fun), .mb_addr(mb_addr),
        .mb_num(mb_num), .exc_en(exc_en), .exc_code(exc_code), .payload_req(payload_req),
        .payload_data(payload_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_last(tx_last), .busy(busy), .tx_done(tx_done), .err_fun(err_fun)
    );

    logic [15:0] ut_crc_in = 16'hFFFF, ut_crc_out;
    logic [7:0]  ut_data = '0;
    crc16_modbus_d8 u_crc_ut (.crc_in(ut_crc_in), .data(ut_data), .crc_out(ut_crc_out));

    int          n_checks = 0, n_errors = 0;
    int          n_req = 0, n_done = 0, n_err = 0, n_valid = 0, n_acc = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  pl_q[$];
    logic        stall_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Bit-serial CRC: shift one data bit at a time through the reflected register.
    function automatic logic [15:0] model_crc(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        logic fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    // Monitor
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = '0;
    logic [8:0] e;
    always @(negedge clk) begin
        if (payload_req) n_req++;
        if (tx_done)     n_done++;
        if (err_fun)     n_err++;
        if (tx_valid)    n_valid++;
        if (!rst_n) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, hold_d);
            end
            if (tx_valid) check("busy_with_valid", busy, 1);
            if (tx_valid && tx_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got %02h required none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e[7:0]);
                    check("tx_last", tx_last, e[8]);
                end
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
        end
    end

    // Payload source: answer each request with the next byte one cycle later, garbage otherwise.
    logic req_seen;
    initial begin
        forever begin
            @(negedge clk);
            req_seen = payload_req;
            @(posedge clk);
            #1;
            if (req_seen && rst_n && pl_q.size() > 0) payload_data = pl_q.pop_front();
            else payload_data = 8'($urandom);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    task automatic send(input logic [7:0] f, input logic [15:0] a, input logic [15:0] n,
                        input logic ex, input logic [7:0] ec,
                        input bit fixed_pl, input bit poke, input bit abort);
        logic [7:0]  fr[$];
        logic [7:0]  b;
        logic [15:0] crc;
        int          exp_req, t;
        bit          bad;
        exp_req = 0;
        bad     = 0;
        t       = 0;
        @(posedge clk); #1;
        while (busy && t < 2000) begin @(posedge clk); #1; t++; end
        if (busy) begin
            n_checks++; n_errors++;
            $display("FAIL idle_timeout: busy=%0b required 0", busy);
        end
        n_req = 0; n_done = 0; n_err = 0; n_valid = 0; n_acc = 0;

        if (ex) begin
            fr.push_back(8'h01); fr.push_back(f | 8'h80); fr.push_back(ec);
        end else if (f == 8'h03 || f == 8'h04) begin
            if (n == 0 || n > 125) begin
                fr.push_back(8'h01); fr.push_back(f | 8'h80); fr.push_back(8'h03);
            end else begin
                fr.push_back(8'h01); fr.push_back(f); fr.push_back(8'(n * 2));
                for (int i = 0; i < int'(n) * 2; i++) begin
                    b = fixed_pl ? 8'hAA + 8'(17 * i) : 8'($urandom);
                    fr.push_back(b);
                    pl_q.push_back(b);
                end
                exp_req = int'(n) * 2;
            end
        end else if (f == 8'h06 || f == 8'h10) begin
            fr.push_back(8'h01); fr.push_back(f);
            fr.push_back(a[15:8]); fr.push_back(a[7:0]);
            fr.push_back(n[15:8]); fr.push_back(n[7:0]);
        end else begin
            bad = 1;
        end
        if (!bad) begin
            crc = 16'hFFFF;
            foreach (fr[i]) crc = model_crc(crc, fr[i]);
            fr.push_back(crc[7:0]);
            fr.push_back(crc[15:8]);
            foreach (fr[i]) exp_q.push_back({(i == fr.size() - 1), fr[i]});
        end

        mb_fun = f; mb_addr = a; mb_num = n; exc_en = ex; exc_code = ec; tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        mb_fun = 8'($urandom); mb_addr = 16'($urandom); mb_num = 16'($urandom);
        exc_code = 8'($urandom); exc_en = 1'($urandom);

        if (bad) begin
            repeat (3) @(posedge clk);
            #1;
            check("err_fun_pulses", n_err, 1);
            check("err_no_valid", n_valid, 0);
            check("err_not_busy", busy, 0);
            return;
        end
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            mb_fun = 8'h2B; exc_en = 1'b0; tx_start = 1'b1;
            @(posedge clk); #1;
            tx_start = 1'b0;
        end
        if (abort) begin
            t = 0;
            while (n_acc < 3 && t < 500) begin @(negedge clk); #1; t++; end
            check("abort_reached_3", n_acc, 3);
            rst_n = 1'b0;
            #1;
            check("rst_tx_valid", tx_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_payload_req", payload_req, 0);
            exp_q.delete();
            pl_q.delete();
            repeat (3) @(posedge clk);
            #1;
            check("rst_no_done", n_done, 0);
            rst_n = 1'b1;
            return;
        end
        t = 0;
        while (n_done == 0 && t < 3000) begin @(posedge clk); #1; t++; end
        if (n_done == 0) begin
            n_checks++; n_errors++;
            $display("FAIL done_timeout: tx_done count 0 required 1");
        end
        check("busy_after_done", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check("tx_done_count", n_done, 1);
        check("payload_req_count", n_req, exp_req);
        check("no_err_fun", n_err, 0);
        check("frame_consumed", exp_q.size(), 0);
    endtask

    logic [7:0] ut_b[6];
    int         sel;
    logic [7:0] rf;
    logic [15:0] rn;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_valid", tx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_tx_done", tx_done, 0);
        check("reset_err_fun", err_fun, 0);
        check("reset_payload_req", payload_req, 0);
        check("reset_tx_last", tx_last, 0);
        rst_n = 1'b1;

        ut_b = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        ut_crc_in = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            ut_data = ut_b[i];
            #1;
            ut_crc_in = ut_crc_out;
        end
        check("crc_unit", ut_crc_in, 16'h0A84);

        send(8'h03, 16'h0000, 16'd2, 1'b0, 8'h00, 1, 0, 0);
        send(8'h10, 16'h0000, 16'h0001, 1'b0, 8'h00, 0, 0, 0);
        send(8'h03, 16'h0000, 16'd0, 1'b0, 8'h00, 0, 0, 0);
        send(8'h03, 16'h0000, 16'd126, 1'b0, 8'h00, 0, 0, 0);
        send(8'h03, 16'h0000, 16'd125, 1'b0, 8'h00, 0, 0, 0);
        send(8'h2B, 16'h0000, 16'd0, 1'b0, 8'h00, 0, 0, 0);
        send(8'h06, 16'h1234, 16'hABCD, 1'b0, 8'h00, 0, 0, 0);
        stall_en = 1'b1;
        send(8'h06, 16'h1234, 16'hABCD, 1'b0, 8'h00, 0, 1, 0);
        send(8'h04, 16'h0010, 16'd3, 1'b1, EXC_ILLEGAL_FUN, 0, 0, 0);
        stall_en = 1'b0;
        send(8'h03, 16'h0000, 16'd3, 1'b0, 8'h00, 0, 0, 1);
        send(8'h03, 16'h0000, 16'd3, 1'b0, 8'h00, 0, 0, 0);

        for (int k = 0; k < 25; k++) begin
            sel = $urandom_range(0, 5);
            rn  = 16'($urandom_range(0, 6));
            case (sel)
                0: rf = 8'h03;
                1: rf = 8'h04;
                2: begin rf = 8'h06; rn = 16'($urandom); end
                3: begin rf = 8'h10; rn = 16'($urandom); end
                4: rf = 8'($urandom);
                default: begin rf = 8'h04; rn = 16'($urandom_range(120, 130)); end
            endcase
            stall_en = 1'($urandom_range(0, 1));
            send(rf, 16'($urandom), rn, ($urandom_range(0, 7) == 0), 8'($urandom), 0, 0, 0);
        end
        stall_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
